// File: rtl/alu_op_dispatcher_pkg.sv
// Shared opcodes and command layout for the ALU issue stage.
// A command is packed as {op, a, b}, so op sits in the top two bits.
package alu_dispatch_pkg;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;
  localparam logic [1:0] OP_SUB = 2'd3;

  localparam int OP_W = 2;

  function automatic int cmd_width(input int w);
    return OP_W + 2 * w;
  endfunction

endpackage

// File: rtl/alu_op_dispatcher_fifo.sv
// Synchronous command FIFO with occupancy count; a push is ignored while full and a pop while empty.
// Pointers wrap naturally because DEPTH is a power of two.
module cmd_fifo
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign level = level_q;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// Issue stage for the operand-isolated ALU: buffers commands, issues one per cycle as
// registered operands plus a one-hot select, drops divide-by-zero and flags result validity.
module alu_op_dispatcher
  import alu_dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic                     stall,
  output logic [W-1:0]             a,
  output logic [W-1:0]             b,
  output logic                     sel1,
  output logic                     sel2,
  output logic                     sel3,
  output logic                     sel4,
  output logic                     res_valid,
  output logic                     div_err,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int CW = cmd_width(W);

  logic [CW-1:0] wdata, rdata;
  logic          full, empty;
  logic          push, pop, div_zero, issue;
  logic [1:0]    head_op;
  logic [W-1:0]  head_a, head_b;

  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [3:0]    sel_q, sel_d;
  logic          res_valid_q, res_valid_d;
  logic          div_err_q, div_err_d;

  // Ready is forced low while reset is held so nothing is accepted into a FIFO being cleared.
  assign cmd_ready = rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign wdata     = {cmd_op, cmd_a, cmd_b};

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign head_op = rdata[CW-1 -: OP_W];
  assign head_a  = rdata[2*W-1 -: W];
  assign head_b  = rdata[W-1:0];

  always_comb begin
    pop         = !empty && !stall;
    div_zero    = (head_op == OP_DIV) && (head_b == '0);
    issue       = pop && !div_zero;
    sel_d       = 4'b0000;
    a_d         = '0;
    b_d         = '0;
    res_valid_d = |sel_q;
    div_err_d   = pop && div_zero;
    if (issue) begin
      a_d = head_a;
      b_d = head_b;
      case (head_op)
        OP_MUL:  sel_d = 4'b0001;
        OP_ADD:  sel_d = 4'b0010;
        OP_DIV:  sel_d = 4'b0100;
        OP_SUB:  sel_d = 4'b1000;
        default: sel_d = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= 4'b0000;
      res_valid_q <= 1'b0;
      div_err_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      res_valid_q <= res_valid_d;
      div_err_q   <= div_err_d;
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign sel1      = sel_q[0];
  assign sel2      = sel_q[1];
  assign sel3      = sel_q[2];
  assign sel4      = sel_q[3];
  assign res_valid = res_valid_q;
  assign div_err   = div_err_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared every
// cycle against a queue-based model of the dispatcher plus a stand-in downstream ALU.
module tb_alu_op_dispatcher;
  import alu_dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int W     = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_op;
  logic [W-1:0]           cmd_a, cmd_b;
  logic                   stall;
  logic [W-1:0]           a, b;
  logic                   sel1, sel2, sel3, sel4;
  logic                   res_valid, div_err;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  alu_op_dispatcher #(.DEPTH(DEPTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .stall      (stall),
    .a          (a),
    .b          (b),
    .sel1       (sel1),
    .sel2       (sel2),
    .sel3       (sel3),
    .sel4       (sel4),
    .res_valid  (res_valid),
    .div_err    (div_err),
    .fifo_level (fifo_level)
  );

  // Arithmetic of the downstream ALU, on a 2W-bit result.
  function automatic logic [2*W-1:0] alu_fn(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] x2, y2;
    x2 = {{W{1'b0}}, x};
    y2 = {{W{1'b0}}, y};
    case (op)
      2'd0:    return x2 * y2;
      2'd1:    return x2 + y2;
      2'd2:    return (y2 != '0) ? x2 / y2 : '0;
      default: return x2 - y2;
    endcase
  endfunction

  // Stand-in ALU: captures whatever the dispatcher presents on the selected function.
  logic [2*W-1:0] alu_out;
  always @(posedge clk or negedge rst) begin
    if (!rst)      alu_out <= '0;
    else if (sel1) alu_out <= alu_fn(2'd0, a, b);
    else if (sel2) alu_out <= alu_fn(2'd1, a, b);
    else if (sel3) alu_out <= alu_fn(2'd2, a, b);
    else if (sel4) alu_out <= alu_fn(2'd3, a, b);
  end

  // Reference model: pending commands in a queue, expected outputs after the latest edge.
  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  cmd_t           mq[$];
  logic [W-1:0]   m_a, m_b;
  logic [3:0]     m_sel;
  logic           m_rv, m_err;
  logic [2*W-1:0] m_res, m_rv_res;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clearModel();
    mq.delete();
    m_a = '0; m_b = '0; m_sel = 4'b0000;
    m_rv = 1'b0; m_err = 1'b0; m_res = '0; m_rv_res = '0;
  endtask

  task automatic checkOutput();
    logic m_ready;
    m_ready = (rst === 1'b1) && (mq.size() < DEPTH);
    check("a", 32'(a), 32'(m_a));
    check("b", 32'(b), 32'(m_b));
    check("sel", 32'({sel4, sel3, sel2, sel1}), 32'(m_sel));
    check("res_valid", 32'(res_valid), 32'(m_rv));
    check("div_err", 32'(div_err), 32'(m_err));
    check("cmd_ready", 32'(cmd_ready), 32'(m_ready));
    check("fifo_level", 32'(fifo_level), 32'(mq.size()));
    if (m_rv) check("alu_out", 32'(alu_out), 32'(m_rv_res));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [W-1:0] ca,
                               input logic [W-1:0] cb, input bit st);
    bit   can_push;
    cmd_t h;
    cmd_valid = v; cmd_op = op; cmd_a = ca; cmd_b = cb; stall = st;
    can_push = v && (mq.size() < DEPTH);
    @(posedge clk);
    m_rv     = (m_sel != 4'b0000);
    m_rv_res = m_res;
    m_err    = 1'b0;
    m_sel    = 4'b0000;
    m_a      = '0;
    m_b      = '0;
    if (mq.size() > 0 && !st) begin
      h = mq.pop_front();
      if (h.op == OP_DIV && h.b == '0) begin
        m_err = 1'b1;
      end else begin
        case (h.op)
          2'd0:    m_sel = 4'b0001;
          2'd1:    m_sel = 4'b0010;
          2'd2:    m_sel = 4'b0100;
          default: m_sel = 4'b1000;
        endcase
        m_a   = h.a;
        m_b   = h.b;
        m_res = alu_fn(h.op, h.a, h.b);
      end
    end
    if (can_push) mq.push_back('{op: op, a: ca, b: cb});
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges, held across one edge, released on a falling edge.
  task automatic resetMidstream();
    cmd_valid = 1'b0; stall = 1'b0;
    #2 rst = 1'b0;
    clearModel();
    #1 checkOutput();
    @(posedge clk);
    #1 checkOutput();
    @(negedge clk) rst = 1'b1;
    #1 checkOutput();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; stall = 1'b0;
    clearModel();
    #1 rst = 1'b0;
    #2 checkOutput();
    @(posedge clk);
    #1 checkOutput();
    @(negedge clk) rst = 1'b1;
    #1 checkOutput();

    $display("[TB] reset with queued commands");
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd2, 1'b1);
    applyStimulus(1'b1, OP_MUL, 4'd3, 4'd2, 1'b1);
    applyStimulus(1'b1, OP_SUB, 4'd7, 4'd1, 1'b1);
    check("t1_level_before_reset", 32'(fifo_level), 32'd3);
    resetMidstream();
    check("t1_level_after_reset", 32'(fifo_level), 32'd0);
    check("t1_ready_after_reset", 32'(cmd_ready), 32'd1);
    idle(3);

    $display("[TB] single ADD");
    applyStimulus(1'b1, OP_ADD, 4'd3, 4'd5, 1'b0);
    idle(1);
    check("t2_sel2", 32'(sel2), 32'd1);
    check("t2_a", 32'(a), 32'd3);
    check("t2_b", 32'(b), 32'd5);
    idle(1);
    check("t2_res_valid", 32'(res_valid), 32'd1);
    check("t2_out", 32'(alu_out), 32'd8);
    idle(2);

    $display("[TB] fill under stall");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 4'(i + 2), 4'(i + 1), 1'b1);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    check("t3_ready_full", 32'(cmd_ready), 32'd0);
    applyStimulus(1'b1, OP_ADD, 4'd9, 4'd9, 1'b1);
    check("t3_level_held", 32'(fifo_level), 32'd4);
    idle(6);

    $display("[TB] divide by zero filter");
    applyStimulus(1'b1, OP_DIV, 4'd7, 4'd0, 1'b0);
    applyStimulus(1'b1, OP_MUL, 4'd2, 4'd3, 1'b0);
    check("t4_div_err", 32'(div_err), 32'd1);
    check("t4_sel_zero", 32'({sel4, sel3, sel2, sel1}), 32'd0);
    idle(1);
    check("t4_sel1", 32'(sel1), 32'd1);
    check("t4_no_rv_for_div", 32'(res_valid), 32'd0);
    idle(1);
    check("t4_out", 32'(alu_out), 32'd6);
    idle(2);

    $display("[TB] stall mid-stream");
    applyStimulus(1'b1, OP_SUB, 4'd9, 4'd4, 1'b0);
    applyStimulus(1'b1, OP_DIV, 4'd8, 4'd2, 1'b0);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    check("t5_sel_stalled", 32'({sel4, sel3, sel2, sel1}), 32'd0);
    check("t5_sub_out", 32'(alu_out), 32'd5);
    applyStimulus(1'b0, 2'd0, '0, '0, 1'b1);
    idle(1);
    check("t5_sel3", 32'(sel3), 32'd1);
    idle(1);
    check("t5_div_out", 32'(alu_out), 32'd4);
    idle(2);

    $display("[TB] simultaneous push/pop and wrap");
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd1, 1'b1);
    applyStimulus(1'b1, OP_SUB, 4'd2, 4'd1, 1'b1);
    applyStimulus(1'b1, OP_MUL, 4'd3, 4'd3, 1'b0);
    check("t6_level_same", 32'(fifo_level), 32'd2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 2'(i % 4), 4'(i + 3), 4'(i + 1), 1'b0);
    idle(6);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if (i == 200) resetMidstream();
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), W'($urandom), rb,
                    ($urandom_range(0, 3) == 0));
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
